// File: rtl/sync_fifo_wr_arbiter_if.sv
// sync_fifo_wr_arbiter_if: handshake bundle between NUM_REQ sources, the write arbiter and a sync_fifo write port
//   i_valid/i_data/o_ready            per-source ready/valid, source k data at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_fifo_valid_s/o_fifo_datain      write strobe and data towards the FIFO
//   i_fifo_ready_s/i_fifo_almostfull  FIFO not-full and almost-full feedback
//   o_grant/o_grant_idx/o_busy        registered grant, its binary index, GRANT-state flag
//   modport master: arbiter side; modport slave: sources/FIFO side
interface sync_fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            i_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
    logic [NUM_REQ-1:0]            o_ready;
    logic                          o_fifo_valid_s;
    logic [DATA_WIDTH-1:0]         o_fifo_datain;
    logic                          i_fifo_ready_s;
    logic                          i_fifo_almostfull;
    logic [NUM_REQ-1:0]            o_grant;
    logic [IDX_WIDTH-1:0]          o_grant_idx;
    logic                          o_busy;

    modport master (
        input  i_valid, i_data, i_fifo_ready_s, i_fifo_almostfull,
        output o_ready, o_fifo_valid_s, o_fifo_datain, o_grant, o_grant_idx, o_busy
    );

    modport slave (
        output i_valid, i_data, i_fifo_ready_s, i_fifo_almostfull,
        input  o_ready, o_fifo_valid_s, o_fifo_datain, o_grant, o_grant_idx, o_busy
    );
endinterface

// File: rtl/sync_fifo_wr_arbiter.sv
// sync_fifo_wr_arbiter: round-robin arbiter sharing one sync_fifo write port between NUM_REQ ready/valid sources
//   i_clk  clock
//   i_rst  synchronous reset, active high; forces every output to 0 while asserted
//   bus    sync_fifo_wr_arbiter_if.master (source handshakes, FIFO write port, grant status)
module sync_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1),
    parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input logic                    i_clk,
    input logic                    i_rst,
    sync_fifo_wr_arbiter_if.master bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d, last_q, last_d, pick_idx;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pick_found, in_grant, valid_g, beat, release_g;
    logic [DATA_WIDTH-1:0] src_data [NUM_REQ];
    int                    cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign src_data[g] = bus.i_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts just after the last released source, so it ends up lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_q) + k) % NUM_REQ;
            if (!pick_found && bus.i_valid[IDX_WIDTH'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_WIDTH'(cand);
            end
        end
    end

    assign in_grant  = state_q == GRANT;
    assign valid_g   = bus.i_valid[idx_q];
    assign beat      = in_grant && valid_g && bus.i_fifo_ready_s;
    // Releasing on an idle source frees the port; almostfull limits each grant to one beat.
    assign release_g = in_grant && (!valid_g || (beat && (cnt_q == CNT_WIDTH'(MAX_BURST - 1) || bus.i_fifo_almostfull)));

    // o_ready depends only on the grant and FIFO space, never on i_valid.
    assign bus.o_ready        = (i_rst || !in_grant) ? '0 : grant_q & {NUM_REQ{bus.i_fifo_ready_s}};
    assign bus.o_fifo_valid_s = !i_rst && beat;
    assign bus.o_fifo_datain  = (i_rst || !in_grant) ? '0 : src_data[idx_q];
    assign bus.o_grant        = i_rst ? '0 : grant_q;
    assign bus.o_grant_idx    = i_rst ? '0 : idx_q;
    assign bus.o_busy         = !i_rst && in_grant;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (!in_grant) begin
            if (pick_found) begin
                state_d = GRANT;
                idx_d   = pick_idx;
                grant_d = NUM_REQ'(1) << pick_idx;
                cnt_d   = '0;
            end
        end else if (release_g) begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
            last_d  = idx_q;
        end else if (beat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= IDX_WIDTH'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// tb_sync_fifo_wr_arbiter: directed checks of the round-robin FIFO write arbiter
module tb_sync_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    int   fcnt;
    int   seq [4];
    logic [3:0] sv;
    logic [1:0] src;
    logic       wr;
    logic       saw_full;
    int         order1 [5] = '{0, 1, 2, 3, 0};
    int         order4 [4] = '{3, 0, 3, 0};

    always #5 clk = ~clk;

    sync_fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    sync_fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_valid = 4'b1111;
        bus.i_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        bus.i_fifo_ready_s = 1'b1;
        bus.i_fifo_almostfull = 1'b0;
        cyc();
        cyc();
        settle();
        chk("rst_grant", bus.o_grant, 0);
        chk("rst_idx", bus.o_grant_idx, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_wr", bus.o_fifo_valid_s, 0);
        chk("rst_ready", bus.o_ready, 0);
        rst = 1'b0;

        // 1: all valid -> 0,1,2,3,0 with four beats each and an idle bubble between
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t1_bubble_busy", bus.o_busy, 0);
            chk("t1_bubble_wr", bus.o_fifo_valid_s, 0);
            cyc();
            for (int b = 0; b < 4; b++) begin
                settle();
                chk("t1_grant", bus.o_grant, 32'(1) << order1[i]);
                chk("t1_idx", bus.o_grant_idx, order1[i]);
                chk("t1_wr", bus.o_fifo_valid_s, 1);
                chk("t1_data", bus.o_fifo_datain, 8'hA0 + 8'h11 * order1[i]);
                chk("t1_ready", bus.o_ready, 32'(1) << order1[i]);
                cyc();
            end
        end
        bus.i_valid = 4'b0000;
        cyc();

        // 2: only src2, valid dropped after two beats
        bus.i_valid = 4'b0100;
        cyc();
        for (int b = 0; b < 2; b++) begin
            settle();
            chk("t2_idx", bus.o_grant_idx, 2);
            chk("t2_wr", bus.o_fifo_valid_s, 1);
            chk("t2_data", bus.o_fifo_datain, 8'hC2);
            cyc();
        end
        bus.i_valid = 4'b0000;
        settle();
        chk("t2_nowr", bus.o_fifo_valid_s, 0);
        chk("t2_still_busy", bus.o_busy, 1);
        cyc();
        settle();
        chk("t2_idle", bus.o_busy, 0);
        chk("t2_grant0", bus.o_grant, 0);

        // 3: src1 bursting, FIFO full for three cycles mid-burst
        bus.i_valid = 4'b0010;
        cyc();
        for (int b = 0; b < 2; b++) begin
            settle();
            chk("t3_wr", bus.o_fifo_valid_s, 1);
            cyc();
        end
        bus.i_fifo_ready_s = 1'b0;
        for (int s = 0; s < 3; s++) begin
            settle();
            chk("t3_stall_wr", bus.o_fifo_valid_s, 0);
            chk("t3_stall_grant", bus.o_grant, 4'b0010);
            chk("t3_stall_ready", bus.o_ready, 0);
            cyc();
        end
        bus.i_fifo_ready_s = 1'b1;
        for (int b = 0; b < 2; b++) begin
            settle();
            chk("t3_resume_wr", bus.o_fifo_valid_s, 1);
            chk("t3_resume_grant", bus.o_grant, 4'b0010);
            cyc();
        end
        settle();
        chk("t3_release", bus.o_busy, 0);
        bus.i_valid = 4'b0000;
        cyc();

        // 4: almostfull -> one beat per grant, srcs 3 and 0 alternate
        bus.i_fifo_almostfull = 1'b1;
        bus.i_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t4_bubble", bus.o_busy, 0);
            cyc();
            settle();
            chk("t4_idx", bus.o_grant_idx, order4[i]);
            chk("t4_wr", bus.o_fifo_valid_s, 1);
            cyc();
        end
        bus.i_valid = 4'b0000;
        bus.i_fifo_almostfull = 1'b0;
        cyc();

        // 5: reset at the second beat of a burst
        bus.i_valid = 4'b1111;
        cyc();
        settle();
        chk("t5_beat1_idx", bus.o_grant_idx, 1);
        chk("t5_beat1_wr", bus.o_fifo_valid_s, 1);
        cyc();
        rst = 1'b1;
        settle();
        chk("t5_rst_wr", bus.o_fifo_valid_s, 0);
        chk("t5_rst_ready", bus.o_ready, 0);
        chk("t5_rst_grant", bus.o_grant, 0);
        cyc();
        rst = 1'b0;
        settle();
        chk("t5_idle", bus.o_busy, 0);
        chk("t5_grant0", bus.o_grant, 0);
        cyc();
        settle();
        chk("t5_src0_first", bus.o_grant, 4'b0001);
        bus.i_valid = 4'b0000;
        cyc();
        settle();
        chk("t5_release", bus.o_busy, 0);

        // 6: random sources into an 8-deep FIFO model with slow draining
        fcnt = 0;
        saw_full = 1'b0;
        sv = 4'b0000;
        for (int k = 0; k < 4; k++) seq[k] = 0;
        for (int n = 0; n < 400; n++) begin
            bus.i_fifo_ready_s = fcnt < 8;
            bus.i_fifo_almostfull = fcnt >= 7;
            bus.i_valid = sv;
            for (int k = 0; k < 4; k++) bus.i_data[k*8 +: 8] = {2'(k), 6'(seq[k])};
            settle();
            wr = bus.o_fifo_valid_s;
            src = bus.o_fifo_datain[7:6];
            if (fcnt == 8) begin
                saw_full = 1'b1;
                chk("t6_no_wr_full", wr, 0);
            end
            if (wr) begin
                chk("t6_src_valid", sv[src], 1);
                chk("t6_order", bus.o_fifo_datain[5:0], 6'(seq[src]));
                chk("t6_accept", bus.o_ready & sv, 32'(1) << src);
                seq[src]++;
                fcnt++;
            end else begin
                chk("t6_no_accept", bus.o_ready & sv, 0);
            end
            if (fcnt > 0 && $urandom_range(0, 3) == 0) fcnt--;
            for (int k = 0; k < 4; k++)
                if (!sv[k] || (wr && int'(src) == k)) sv[k] = 1'($urandom_range(0, 1));
            cyc();
        end
        chk("t6_full_seen", saw_full, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
